// File: rtl/syn_acortex_lb_arb.sv
// Two-port round-robin arbiter and transaction sequencer for the ACORTEX Local Bus.
// One transaction in flight at a time; slave is decoded from the top two address bits.
module syn_acortex_lb_arb #(
    parameter int LB_ADDR_W = 8,
    parameter int LB_DATA_W = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                      clk_ir,
    input  logic                      rst_il,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_wr,
    input  logic [1:0][LB_ADDR_W-1:0] req_addr,
    input  logic [1:0][LB_DATA_W-1:0] req_wdata,
    output logic [1:0]                rsp_valid,
    output logic                      rsp_err,
    output logic [LB_DATA_W-1:0]      rsp_rdata,
    output logic                      i2cm_wr_en,
    output logic                      i2cm_rd_en,
    output logic                      cmux_wr_en,
    output logic                      cmux_rd_en,
    output logic                      wmdrvr_wr_en,
    output logic                      wmdrvr_rd_en,
    output logic                      acache_wr_en,
    output logic                      acache_rd_en,
    output logic [LB_ADDR_W-1:0]      lbm_addr,
    output logic [LB_DATA_W-1:0]      lbm_wr_data,
    input  logic                      lbm_wr_valid,
    input  logic                      lbm_rd_valid,
    input  logic [LB_DATA_W-1:0]      lbm_rd_data,
    output logic [15:0]               err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // Counter value on the last allowed wait cycle (2^W-1 wait cycles total).
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               state;
    logic                 last_gnt;
    logic                 port_q;
    logic                 wr_q;
    logic [7:0]           en_q;
    logic [TIMEOUT_W-1:0] tmo_cnt;

    logic [1:0] gnt;
    logic       sel;
    logic       done;
    logic       tmo_hit;

    // Enable vector bit order: {slave, ~wr}, so even bits are writes.
    function automatic logic [7:0] en_dec(input logic [1:0] slv, input logic wr);
        logic [7:0] v;
        v = 8'h00;
        v[{slv, ~wr}] = 1'b1;
        return v;
    endfunction

    // Grant: single requester wins; on contention the port not served last wins.
    always_comb begin
        gnt = 2'b00;
        if (state == S_IDLE) begin
            if (req_valid == 2'b11) begin
                gnt = last_gnt ? 2'b01 : 2'b10;
            end else begin
                gnt = req_valid;
            end
        end
    end

    assign req_ready = gnt;
    assign sel       = gnt[1];
    assign done      = (state == S_WAIT) && (wr_q ? lbm_wr_valid : lbm_rd_valid);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    assign i2cm_wr_en   = en_q[0];
    assign i2cm_rd_en   = en_q[1];
    assign cmux_wr_en   = en_q[2];
    assign cmux_rd_en   = en_q[3];
    assign wmdrvr_wr_en = en_q[4];
    assign wmdrvr_rd_en = en_q[5];
    assign acache_wr_en = en_q[6];
    assign acache_rd_en = en_q[7];

    // Transaction sequencer: accept, hold the bus until valid or timeout, respond.
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state       <= S_IDLE;
            last_gnt    <= 1'b1;
            port_q      <= 1'b0;
            wr_q        <= 1'b0;
            en_q        <= 8'h00;
            tmo_cnt     <= '0;
            rsp_valid   <= 2'b00;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            lbm_addr    <= '0;
            lbm_wr_data <= '0;
            err_cnt     <= 16'h0000;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|gnt) begin
                        port_q      <= sel;
                        last_gnt    <= sel;
                        wr_q        <= req_wr[sel];
                        lbm_addr    <= req_addr[sel];
                        lbm_wr_data <= req_wdata[sel];
                        en_q        <= en_dec(req_addr[sel][LB_ADDR_W-1 -: 2],
                                              req_wr[sel]);
                        tmo_cnt     <= '0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        en_q      <= 8'h00;
                        rsp_valid <= port_q ? 2'b10 : 2'b01;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= wr_q ? '0 : lbm_rd_data;
                        state     <= S_RESP;
                    end else if (tmo_hit) begin
                        en_q      <= 8'h00;
                        rsp_valid <= port_q ? 2'b10 : 2'b01;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        if (err_cnt != 16'hFFFF) begin
                            err_cnt <= err_cnt + 16'd1;
                        end
                        state     <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 2'b00;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_syn_acortex_lb_arb.sv
// Directed bench for syn_acortex_lb_arb with a response scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_syn_acortex_lb_arb;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0]           req_wr;
    logic [1:0][AW-1:0]   req_addr;
    logic [1:0][DW-1:0]   req_wdata;
    logic [1:0]           rsp_valid;
    logic                 rsp_err;
    logic [DW-1:0]        rsp_rdata;
    logic                 i2cm_wr_en, i2cm_rd_en, cmux_wr_en, cmux_rd_en;
    logic                 wmdrvr_wr_en, wmdrvr_rd_en, acache_wr_en, acache_rd_en;
    logic [AW-1:0]        lbm_addr;
    logic [DW-1:0]        lbm_wr_data;
    logic                 lbm_wr_valid;
    logic                 lbm_rd_valid;
    logic [DW-1:0]        lbm_rd_data;
    logic [15:0]          err_cnt;
    logic [7:0]           en_vec;

    always #5 clk = ~clk;

    syn_acortex_lb_arb #(
        .LB_ADDR_W (AW),
        .LB_DATA_W (DW),
        .TIMEOUT_W (TW)
    ) dut (
        .clk_ir       (clk),
        .rst_il       (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .i2cm_wr_en   (i2cm_wr_en),
        .i2cm_rd_en   (i2cm_rd_en),
        .cmux_wr_en   (cmux_wr_en),
        .cmux_rd_en   (cmux_rd_en),
        .wmdrvr_wr_en (wmdrvr_wr_en),
        .wmdrvr_rd_en (wmdrvr_rd_en),
        .acache_wr_en (acache_wr_en),
        .acache_rd_en (acache_rd_en),
        .lbm_addr     (lbm_addr),
        .lbm_wr_data  (lbm_wr_data),
        .lbm_wr_valid (lbm_wr_valid),
        .lbm_rd_valid (lbm_rd_valid),
        .lbm_rd_data  (lbm_rd_data),
        .err_cnt      (err_cnt)
    );

    assign en_vec = {acache_rd_en, acache_wr_en, wmdrvr_rd_en, wmdrvr_wr_en,
                     cmux_rd_en, cmux_wr_en, i2cm_rd_en, i2cm_wr_en};

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Expected one-hot enable: slave index from addr[7:6], write on even bit.
    function automatic logic [7:0] en_exp(input logic [7:0] addr, input logic wr);
        int         idx;
        logic [7:0] m;
        idx = int'(addr[7:6]) * 2 + (wr ? 0 : 1);
        m = 8'h01;
        return m << idx;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the falling edge of the cycle a response is due.
    task automatic check_rsp(input string tag);
        exp_t e;
        logic [1:0] pv;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        pv = 2'b01 << e.port;
        chk({tag, "_rsp_valid"}, rsp_valid, pv);
        chk({tag, "_rsp_err"}, rsp_err, e.err);
        chk({tag, "_rsp_rdata"}, rsp_rdata, e.rdata);
    endtask

    // vcyc = wait cycle of the matching valid (0 = never, expect timeout);
    // wrong = wait cycle of a valid of the opposite type (0 = none).
    task automatic run_txn(input string tag, input int p, input logic wr,
                           input logic [7:0] addr, input logic [31:0] wd,
                           input int vcyc, input logic [31:0] rd, input int wrong);
        logic [7:0] en;
        logic [1:0] pv;
        int         lim;
        int         w;
        exp_t       e;
        en = en_exp(addr, wr);
        pv = 2'b01 << p;
        @(posedge clk); #1;
        req_valid[p] = 1'b1;
        req_wr[p]    = wr;
        req_addr[p]  = addr;
        req_wdata[p] = wd;
        w = 0;
        @(negedge clk);
        while (!req_ready[p] && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready"}, req_ready, pv);
        e.port  = p;
        e.err   = (vcyc == 0);
        e.rdata = (vcyc == 0 || wr) ? 32'h0 : rd;
        sb.push_back(e);
        lim = (vcyc == 0) ? (1 << TW) - 1 : vcyc;
        for (int k = 1; k <= lim; k++) begin
            @(posedge clk); #1;
            req_valid[p] = 1'b0;
            req_addr[p]  = 8'($urandom);
            req_wdata[p] = $urandom;
            lbm_wr_valid = (k == vcyc && wr) || (k == wrong && !wr);
            lbm_rd_valid = (k == vcyc && !wr) || (k == wrong && wr);
            lbm_rd_data  = (k == vcyc) ? rd : $urandom;
            @(negedge clk);
            chk({tag, "_en"}, en_vec, en);
            chk({tag, "_addr"}, lbm_addr, addr);
            if (wr) chk({tag, "_wdata"}, lbm_wr_data, wd);
            chk({tag, "_no_rsp"}, rsp_valid, 2'b00);
        end
        @(posedge clk); #1;
        lbm_wr_valid = 1'b0;
        lbm_rd_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_en_off"}, en_vec, 8'h00);
        check_rsp(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         grants;
        int         cyc;
        int         exp_g;
        int         last_p;
        logic [1:0] pv;
        exp_t       e;

        rst_n        = 1'b0;
        req_valid    = 2'b00;
        req_wr       = 2'b00;
        req_addr     = '0;
        req_wdata    = '0;
        lbm_wr_valid = 1'b0;
        lbm_rd_valid = 1'b0;
        lbm_rd_data  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_en", en_vec, 8'h00);
        chk("rst_addr", lbm_addr, 8'h00);
        chk("rst_wdata", lbm_wr_data, 32'h0);
        chk("rst_err_cnt", err_cnt, 16'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Contention straight out of reset: grants alternate starting at port 0
        @(posedge clk); #1;
        req_wr       = 2'b00;
        req_addr[0]  = 8'h05;
        req_addr[1]  = 8'h85;
        req_valid    = 2'b11;
        lbm_rd_valid = 1'b1;
        lbm_rd_data  = 32'h600DCAFE;
        grants = 0;
        cyc    = 0;
        exp_g  = 0;
        last_p = -1;
        while ((grants < 4 || sb.size() > 0) && cyc < 40) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                if (grants >= 4) req_valid = 2'b00;
            end
            @(negedge clk);
            cyc++;
            if (last_p >= 0) begin
                chk("cont_en", en_vec, en_exp(last_p == 0 ? 8'h05 : 8'h85, 1'b0));
                last_p = -1;
            end
            if (rsp_valid != 2'b00) check_rsp("cont");
            if (req_ready != 2'b00) begin
                pv = 2'b01 << exp_g;
                chk("cont_gnt", req_ready, pv);
                e.port  = exp_g;
                e.err   = 1'b0;
                e.rdata = 32'h600DCAFE;
                sb.push_back(e);
                last_p = exp_g;
                exp_g ^= 1;
                grants++;
            end
        end
        chk("cont_grants", 64'(grants), 64'd4);
        @(posedge clk); #1;
        req_valid    = 2'b00;
        lbm_rd_valid = 1'b0;

        // Port 0 write to cmux, valid on the third wait cycle
        run_txn("p0_wr", 0, 1'b1, 8'h45, 32'h0000_1234, 3, 32'h0, 0);
        // Port 1 read from acache, immediate valid
        run_txn("p1_rd", 1, 1'b0, 8'hC2, 32'h0, 1, 32'hDEAD_BEEF, 0);
        // Write with a stray read valid before the real write valid
        run_txn("wrong_type", 0, 1'b1, 8'h85, 32'h0000_CAFE, 3, 32'h0, 1);
        // Timeout on an i2cm read
        run_txn("tmo", 1, 1'b0, 8'h10, 32'h0, 0, 32'h0, 0);
        chk("tmo_err_cnt", err_cnt, 16'd1);
        // Valid on the last wait cycle wins over the timeout
        run_txn("tmo_edge", 0, 1'b0, 8'h50, 32'h0, (1 << TW) - 1, 32'h0BAD_F00D, 0);
        chk("tmo_edge_err_cnt", err_cnt, 16'd1);

        // Async reset in the middle of a port 0 write
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        req_wr[0]    = 1'b1;
        req_addr[0]  = 8'h60;
        req_wdata[0] = 32'h5555_AAAA;
        @(negedge clk);
        chk("arst_ready", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #3;
        chk("arst_pre_en", en_vec, en_exp(8'h60, 1'b1));
        rst_n = 1'b0;
        #1;
        chk("arst_en", en_vec, 8'h00);
        chk("arst_rsp", rsp_valid, 2'b00);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_post_rsp", rsp_valid, 2'b00);
            chk("arst_post_en", en_vec, 8'h00);
        end

        // After reset port 0 again wins contention
        @(posedge clk); #1;
        req_wr      = 2'b00;
        req_addr[0] = 8'h05;
        req_addr[1] = 8'h85;
        req_valid   = 2'b11;
        @(negedge clk);
        chk("arst_prio", req_ready, 2'b01);
        e.port  = 0;
        e.err   = 1'b0;
        e.rdata = 32'h1234_5678;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid    = 2'b00;
        lbm_rd_valid = 1'b1;
        lbm_rd_data  = 32'h1234_5678;
        @(negedge clk);
        chk("arst_prio_en", en_vec, en_exp(8'h05, 1'b0));
        @(posedge clk); #1;
        lbm_rd_valid = 1'b0;
        @(negedge clk);
        check_rsp("arst_prio");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
